// File: rtl/sig_path_pkg.sv
// Shared types and constants for the coefficient update path: axis encoding,
// tap/coefficient widths and the queued update command record.
package sig_path_pkg;

   localparam int N_TAPS  = 16;
   localparam int COEFF_W = 16;
   localparam int IDX_W   = $clog2(N_TAPS);

   typedef enum logic [1:0] {
      AXIS_X   = 2'd0,
      AXIS_Y   = 2'd1,
      AXIS_Z   = 2'd2,
      AXIS_BAD = 2'd3
   } axis_t;

   typedef struct packed {
      axis_t              axis;
      logic [1:0]         bank;
      logic [IDX_W-1:0]   index;
      logic [COEFF_W-1:0] value;
   } update_cmd_t;

endpackage

// File: rtl/coeff_update_sched_cmd_fifo.sv
// Synchronous FIFO of update commands with same-cycle push/pop; a push into a
// full FIFO is accepted only when a pop frees the head slot in that cycle.
module cmd_fifo
   import sig_path_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  update_cmd_t push_data,
   input  logic        pop,
   output update_cmd_t head,
   output logic        empty,
   output logic        full,
   output logic        single
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0] CNT_ONE  = 1;

   update_cmd_t      mem_q [DEPTH];
   update_cmd_t      mem_d [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign count  = wr_ptr_q - rd_ptr_q;
   assign empty  = (count == '0);
   assign full   = (count == CNT_FULL);
   assign single = (count == CNT_ONE);
   assign head   = mem_q[rd_ptr_q[PTR_W-1:0]];

   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/coeff_update_sched.sv
// Schedules CPU coefficient updates into single-cycle RAM writes and applies
// bank swaps at sample boundaries. Optional counters: COEFF_UPDATE_COUNT_EN.
//
// state    | meaning
// IDLE     | command FIFO empty, no write pending
// ISSUE    | popping issuable head entries, one write per cycle
// STALL    | head targets the active bank while filter is busy
module coeff_update_sched
   import sig_path_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic               update_en,
   input  logic [1:0]         update_axis,
   input  logic [1:0]         update_bank,
   input  logic [IDX_W-1:0]   update_index,
   input  logic [COEFF_W-1:0] update_value,
   input  logic [1:0]         req_x_bank,
   input  logic [1:0]         req_y_bank,
   input  logic [1:0]         req_z_bank,
   input  logic               sample_strobe,
   input  logic               filter_busy,
   output logic [1:0]         x_bank,
   output logic [1:0]         y_bank,
   output logic [1:0]         z_bank,
   output logic               coeff_we,
   output logic [1:0]         coeff_axis,
   output logic [1:0]         coeff_bank,
   output logic [IDX_W-1:0]   coeff_index,
   output logic [COEFF_W-1:0] coeff_data,
   output logic               sched_busy,
   output logic               overflow,
   output logic               bad_axis,
   output logic [15:0]        update_count,
   output logic [7:0]         drop_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   logic [1:0]         state_q, state_d;
   logic               upd_en_q;
   logic [1:0]         x_bank_q, x_bank_d, y_bank_q, y_bank_d, z_bank_q, z_bank_d;
   logic               coeff_we_q, coeff_we_d;
   logic [1:0]         coeff_axis_q, coeff_axis_d, coeff_bank_q, coeff_bank_d;
   logic [IDX_W-1:0]   coeff_index_q, coeff_index_d;
   logic [COEFF_W-1:0] coeff_data_q, coeff_data_d;
   logic               overflow_q, overflow_d, bad_axis_q, bad_axis_d;

   logic        cmd_valid, cmd_bad, push, drop_full, pop, head_ok, swap;
   logic [1:0]  head_active;
   update_cmd_t cmd_in, head;
   logic        fifo_empty, fifo_full, fifo_single;

   assign cmd_valid = update_en & ~upd_en_q;
   assign cmd_bad   = cmd_valid & (update_axis == 2'd3);
   assign push      = cmd_valid & ~cmd_bad;
   assign drop_full = push & fifo_full & ~pop;

   assign cmd_in = '{axis: axis_t'(update_axis), bank: update_bank,
                     index: update_index, value: update_value};

   cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (sys_clk),
      .rst       (reset),
      .push      (push),
      .push_data (cmd_in),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .single    (fifo_single)
   );

   always_comb begin
      case (head.axis)
         AXIS_X:  head_active = x_bank_q;
         AXIS_Y:  head_active = y_bank_q;
         default: head_active = z_bank_q;
      endcase
   end

   // Writing the bank currently in use is only safe between MACs.
   assign head_ok = ~fifo_empty & ((head.bank != head_active) | ~filter_busy);

   always_comb begin
      pop     = 1'b0;
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_ISSUE: begin
            if (fifo_empty) begin
               state_d = ST_IDLE;
            end else if (head_ok) begin
               pop     = 1'b1;
               state_d = (fifo_single & ~push) ? ST_IDLE : ST_ISSUE;
            end else begin
               state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            if (head_ok) begin
               pop     = 1'b1;
               state_d = (fifo_single & ~push) ? ST_IDLE : ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      coeff_we_d    = pop;
      coeff_axis_d  = coeff_axis_q;
      coeff_bank_d  = coeff_bank_q;
      coeff_index_d = coeff_index_q;
      coeff_data_d  = coeff_data_q;
      if (pop) begin
         coeff_axis_d  = head.axis;
         coeff_bank_d  = head.bank;
         coeff_index_d = head.index;
         coeff_data_d  = head.value;
      end
   end

   assign swap = sample_strobe & fifo_empty & ~coeff_we_q;

   always_comb begin
      x_bank_d   = swap ? req_x_bank : x_bank_q;
      y_bank_d   = swap ? req_y_bank : y_bank_q;
      z_bank_d   = swap ? req_z_bank : z_bank_q;
      overflow_d = overflow_q | drop_full;
      bad_axis_d = bad_axis_q | cmd_bad;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         upd_en_q      <= 1'b0;
         x_bank_q      <= '0;
         y_bank_q      <= '0;
         z_bank_q      <= '0;
         coeff_we_q    <= 1'b0;
         coeff_axis_q  <= '0;
         coeff_bank_q  <= '0;
         coeff_index_q <= '0;
         coeff_data_q  <= '0;
         overflow_q    <= 1'b0;
         bad_axis_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         upd_en_q      <= update_en;
         x_bank_q      <= x_bank_d;
         y_bank_q      <= y_bank_d;
         z_bank_q      <= z_bank_d;
         coeff_we_q    <= coeff_we_d;
         coeff_axis_q  <= coeff_axis_d;
         coeff_bank_q  <= coeff_bank_d;
         coeff_index_q <= coeff_index_d;
         coeff_data_q  <= coeff_data_d;
         overflow_q    <= overflow_d;
         bad_axis_q    <= bad_axis_d;
      end
   end

   assign x_bank      = x_bank_q;
   assign y_bank      = y_bank_q;
   assign z_bank      = z_bank_q;
   assign coeff_we    = coeff_we_q;
   assign coeff_axis  = coeff_axis_q;
   assign coeff_bank  = coeff_bank_q;
   assign coeff_index = coeff_index_q;
   assign coeff_data  = coeff_data_q;
   assign overflow    = overflow_q;
   assign bad_axis    = bad_axis_q;
   assign sched_busy  = ~fifo_empty | coeff_we_q;

`ifdef COEFF_UPDATE_COUNT_EN
   logic [15:0] update_count_q, update_count_d;
   logic [7:0]  drop_count_q, drop_count_d;

   always_comb begin
      update_count_d = update_count_q;
      drop_count_d   = drop_count_q;
      if (coeff_we_q && (update_count_q != 16'hFFFF)) begin
         update_count_d = update_count_q + 16'd1;
      end
      if ((cmd_bad || drop_full) && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         update_count_q <= '0;
         drop_count_q   <= '0;
      end else begin
         update_count_q <= update_count_d;
         drop_count_q   <= drop_count_d;
      end
   end

   assign update_count = update_count_q;
   assign drop_count   = drop_count_q;
`else
   assign update_count = '0;
   assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_coeff_update_sched.sv
// Directed bench for coeff_update_sched: write latency, edge detect, stalls,
// overflow, bank swap gating, bad axis and mid-stream reset.
module tb_coeff_update_sched;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        update_en;
   logic [1:0]  update_axis, update_bank;
   logic [3:0]  update_index;
   logic [15:0] update_value;
   logic [1:0]  req_x_bank, req_y_bank, req_z_bank;
   logic        sample_strobe, filter_busy;
   logic [1:0]  x_bank, y_bank, z_bank;
   logic        coeff_we;
   logic [1:0]  coeff_axis, coeff_bank;
   logic [3:0]  coeff_index;
   logic [15:0] coeff_data;
   logic        sched_busy, overflow, bad_axis;
   logic [15:0] update_count;
   logic [7:0]  drop_count;

   int checks = 0;
   int errors = 0;
   int we_cnt;

   always #5 sys_clk = ~sys_clk;

   coeff_update_sched dut (
      .sys_clk       (sys_clk),
      .reset         (reset),
      .update_en     (update_en),
      .update_axis   (update_axis),
      .update_bank   (update_bank),
      .update_index  (update_index),
      .update_value  (update_value),
      .req_x_bank    (req_x_bank),
      .req_y_bank    (req_y_bank),
      .req_z_bank    (req_z_bank),
      .sample_strobe (sample_strobe),
      .filter_busy   (filter_busy),
      .x_bank        (x_bank),
      .y_bank        (y_bank),
      .z_bank        (z_bank),
      .coeff_we      (coeff_we),
      .coeff_axis    (coeff_axis),
      .coeff_bank    (coeff_bank),
      .coeff_index   (coeff_index),
      .coeff_data    (coeff_data),
      .sched_busy    (sched_busy),
      .overflow      (overflow),
      .bad_axis      (bad_axis),
      .update_count  (update_count),
      .drop_count    (drop_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_cmd(input logic [1:0] axis, input logic [1:0] bank,
                          input logic [3:0] idx, input logic [15:0] val);
      update_axis  = axis;
      update_bank  = bank;
      update_index = idx;
      update_value = val;
   endtask

   // One-cycle update_en pulse followed by one low cycle.
   task automatic send(input logic [1:0] axis, input logic [1:0] bank,
                       input logic [3:0] idx, input logic [15:0] val);
      set_cmd(axis, bank, idx, val);
      update_en = 1'b1;
      tick();
      update_en = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; update_en = 1'b0; set_cmd(2'd0, 2'd0, 4'd0, 16'h0);
      req_x_bank = 2'd0; req_y_bank = 2'd0; req_z_bank = 2'd0;
      sample_strobe = 1'b0; filter_busy = 1'b0;
      tick(); tick();
      check("rst_we", coeff_we, 0);
      check("rst_busy", sched_busy, 0);
      check("rst_flags", {overflow, bad_axis}, 0);
      check("rst_banks", {x_bank, y_bank, z_bank}, 0);
      check("rst_data", coeff_data, 0);
      check("rst_counts", {update_count, drop_count}, 0);
      reset = 1'b0;
      tick();

      // single write: X bank 1 while x_bank=0
      set_cmd(2'd0, 2'd1, 4'd5, 16'h1234);
      update_en = 1'b1;
      tick();
      check("single_k1_we", coeff_we, 0);
      check("single_k1_busy", sched_busy, 1);
      update_en = 1'b0;
      tick();
      check("single_we", coeff_we, 1);
      check("single_fields", {coeff_axis, coeff_bank, coeff_index, coeff_data}, {2'd0, 2'd1, 4'd5, 16'h1234});
      tick();
      check("single_we_off", coeff_we, 0);
      check("single_busy_off", sched_busy, 0);
      check("single_hold", coeff_data, 16'h1234);

      // level held high for 10 cycles gives one write
      set_cmd(2'd1, 2'd2, 4'd3, 16'hBEEF);
      update_en = 1'b1;
      we_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 10) update_en = 1'b0;
         tick();
         we_cnt += int'(coeff_we);
      end
      check("level_one_write", we_cnt, 1);
      check("level_data", coeff_data, 16'hBEEF);

      // active-bank stall on Y bank 0, then Y bank 1 queued behind it
      filter_busy = 1'b1;
      send(2'd1, 2'd0, 4'd7, 16'h1111);
      send(2'd1, 2'd1, 4'd8, 16'h2222);
      we_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         we_cnt += int'(coeff_we);
      end
      check("stall_no_we", we_cnt, 0);
      check("stall_busy", sched_busy, 1);
      filter_busy = 1'b0;
      tick();
      check("stall_rel_we", coeff_we, 1);
      check("stall_rel_fields", {coeff_axis, coeff_bank, coeff_index, coeff_data}, {2'd1, 2'd0, 4'd7, 16'h1111});
      tick();
      check("stall_next_we", coeff_we, 1);
      check("stall_next_fields", {coeff_bank, coeff_index, coeff_data}, {2'd1, 4'd8, 16'h2222});
      tick();
      check("stall_done", {coeff_we, sched_busy}, 0);

      // overflow: 5 commands to active X bank 0 while busy
      filter_busy = 1'b1;
      for (int i = 0; i < 5; i++) send(2'd0, 2'd0, 4'(i), 16'h0100 + 16'(i));
      check("ovf_flag", overflow, 1);
      check("ovf_no_we", coeff_we, 0);
      filter_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("ovf_we%0d", i), coeff_we, 1);
         check($sformatf("ovf_idx%0d", i), {coeff_index, coeff_data}, {4'(i), 16'h0100 + 16'(i)});
      end
      tick();
      check("ovf_end", {coeff_we, sched_busy}, 0);
      check("ovf_sticky", overflow, 1);

      // bank swap gated by a non-empty FIFO
      req_z_bank = 2'd2;
      filter_busy = 1'b1;
      send(2'd2, 2'd0, 4'd9, 16'h3333);
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      check("swap_blocked", z_bank, 0);
      filter_busy = 1'b0;
      tick();
      check("swap_pending_we", coeff_we, 1);
      tick();
      check("swap_still_old", z_bank, 0);
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      check("swap_applied", z_bank, 2);
      check("swap_xy", {x_bank, y_bank}, 0);

      // bad axis dropped
      send(2'd3, 2'd1, 4'd1, 16'hDEAD);
      check("bad_flag", bad_axis, 1);
      check("bad_no_write", {coeff_we, sched_busy}, 0);

      // reset with two queued entries
      filter_busy = 1'b1;
      send(2'd0, 2'd0, 4'd2, 16'h4444);
      send(2'd0, 2'd0, 4'd3, 16'h5555);
      check("rst2_busy", sched_busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      filter_busy = 1'b0;
      we_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         we_cnt += int'(coeff_we);
      end
      check("rst2_no_we", we_cnt, 0);
      check("rst2_flags", {overflow, bad_axis, sched_busy}, 0);
      check("rst2_zbank", z_bank, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/coeff_update_sched.md
Name: coeff_update_sched

Overview:
- Sits between the Nios PIO update/bank registers and the 16-tap signal path; runs in the sys_clk domain.
- Turns CPU update commands into single-cycle coefficient RAM writes, buffering them in a small FIFO.
- Holds back writes that would corrupt an active bank while the filter is running a MAC.
- Applies CPU bank-select changes only at sample boundaries, so each sample is filtered with one coherent coefficient set.

Parameters:
- N_TAPS, 16, taps per bank; index width = $clog2(N_TAPS).
- COEFF_W, 16, coefficient width.
- FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2).

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- update_en  in  1  PIO level; each rising edge is one command
- update_axis  in  2  0=X, 1=Y, 2=Z, 3=invalid
- update_bank  in  2  target bank
- update_index  in  4  tap index
- update_value  in  COEFF_W  coefficient value
- req_x_bank / req_y_bank / req_z_bank  in  2 each  CPU-requested banks
- sample_strobe  in  1  1-cycle pulse at the start of each new sample
- filter_busy  in  1  MAC in progress
- x_bank / y_bank / z_bank  out  2 each  active banks driven to the signal path
- coeff_we  out  1  write strobe
- coeff_axis  out  2  write target axis
- coeff_bank  out  2  write target bank
- coeff_index  out  4  write target tap index
- coeff_data  out  COEFF_W  write data
- sched_busy  out  1  FIFO non-empty or write in flight
- overflow  out  1  sticky: command dropped because FIFO was full
- bad_axis  out  1  sticky: axis=3 command dropped

Behaviour:
- Reset: all outputs 0, FIFO empty, edge register 0, FSM in IDLE.
- Edge detect:
  - A command is present when update_en=1 and the registered previous update_en=0.
  - A level held high yields exactly one command.
- Enqueue:
  - A command with axis=3 is never enqueued; bad_axis is set.
  - When the FIFO is full with no pop that cycle, the command is dropped and overflow is set.
  - When the FIFO is full and a pop occurs the same cycle, the push is accepted.
- Issuability of the FIFO head:
  - Issuable if head.bank != active bank of head.axis.
  - Otherwise issuable only if filter_busy=0.
  - Strict in-order: a stalled head blocks all later entries.
- FSM:
  - IDLE: FIFO empty. Go to ISSUE on non-empty.
  - ISSUE:
    - Head issuable: pop it; next cycle coeff_we=1 with the head fields registered. Stay in ISSUE if more entries remain, else go to IDLE.
    - Head not issuable: go to STALL.
  - STALL: coeff_we=0. Return to ISSUE in the cycle the head becomes issuable.
- Write throughput and latency:
  - At most one write per cycle; back-to-back writes are allowed.
  - coeff_* are registered and hold their last value when coeff_we=0.
  - Latency: update_en high in cycle k (edge) -> entry visible after edge k -> coeff_we=1 in cycle k+2 when issuable.
- Bank swap:
  - On sample_strobe, each active bank copies its req_*_bank, but only if the FIFO is empty and coeff_we=0 in that cycle.
  - Otherwise the swap is deferred to the next qualifying strobe.
  - The new bank is visible the cycle after the strobe.
- sched_busy = FIFO non-empty OR coeff_we.
- Reset mid-stream: queued commands are discarded, no write strobe follows, and the sticky flags clear.

Optional Feature:
- Macro: COEFF_UPDATE_COUNT_EN.
- Defined:
  - Adds output update_count[15:0], reset 0.
  - Increments on each coeff_we and saturates at 16'hFFFF.
  - Adds output drop_count[7:0], which increments per dropped command (overflow or bad axis) and saturates at 8'hFF.
- Undefined: both ports still exist and are tied to 0; no counter logic is generated.

Decomposition:
- Shared package sig_path_pkg:
  - axis_t enum (AXIS_X=0, AXIS_Y=1, AXIS_Z=2, AXIS_BAD=3).
  - Constants N_TAPS, COEFF_W.
  - Packed struct update_cmd_t {axis, bank, index, value}.
- Sub-module cmd_fifo: parameterised synchronous FIFO of update_cmd_t with full/empty flags and same-cycle push/pop.

Test Plan:
- Single write: pulse update_en with X, bank 1, index 5, value 16'h1234, x_bank=0 -> coeff_we one cycle at k+2 with those fields; sched_busy low after.
- Level held: update_en held high for 10 cycles -> exactly one coeff_we.
- Active-bank stall: Y bank 0 active, filter_busy=1, write to Y bank 0 -> no coeff_we until filter_busy drops, then the write issues on the next cycle. A later write to Y bank 1 queued behind it issues the cycle after.
- Overflow: filter_busy=1 with 5 commands to the active bank (depth 4) -> 4 queued, overflow=1. Drop filter_busy -> exactly 4 back-to-back writes.
- Bank swap gating: req_z_bank=2 with FIFO non-empty at sample_strobe -> z_bank unchanged. Next strobe with FIFO empty -> z_bank=2 the following cycle.
- Bad axis and reset: axis=3 command -> no write, bad_axis=1. Assert reset with 2 entries queued -> no coeff_we afterwards, all flags 0.
